// File: rtl/la_clkgatectrl.sv
// rtl/la_clkgatectrl.sv - activity-driven enable controller for an OR-style clock gate
// Gates after IDLE quiet cycles, re-enables on activity, acks wake requests after settling.
module la_clkgatectrl #(
  parameter        PROP = "DEFAULT",
  parameter int    IDLE = 16,
  parameter int    WAKE = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic busy,
  input  logic req,
  input  logic force_on,
  input  logic te,
  output logic en,
  output logic ack,
  output logic gated
);

  localparam int IcW = $clog2(IDLE + 1);
  localparam int WcW = $clog2(WAKE + 1);

  localparam logic [IcW-1:0] IdleLast = IcW'(IDLE - 1);
  localparam logic [IcW-1:0] IdleMax  = IcW'(IDLE);
  localparam logic [WcW-1:0] WakeLast = WcW'(WAKE - 1);
  localparam logic [WcW-1:0] WakeMax  = WcW'(WAKE);

  // PROP only tags the implementation; it does not alter behaviour.
  if ($bits(PROP) == 0) begin : g_no_prop
  end

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_GATED = 2'd1,
    ST_WAKE  = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [IcW-1:0] idle_cnt_q, idle_cnt_d;
  logic [WcW-1:0] wake_cnt_q, wake_cnt_d;
  logic           en_q, en_d;
  logic           ack_q, ack_d;
  logic           gated_q, gated_d;
  logic           act;

  assign act = busy | req | force_on | te;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_RUN;
      idle_cnt_q <= '0;
      wake_cnt_q <= '0;
      en_q       <= 1'b1;
      ack_q      <= 1'b0;
      gated_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
      wake_cnt_q <= wake_cnt_d;
      en_q       <= en_d;
      ack_q      <= ack_d;
      gated_q    <= gated_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    wake_cnt_d = wake_cnt_q;
    if (te) begin
      state_d    = ST_RUN;
      idle_cnt_d = '0;
      wake_cnt_d = '0;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          wake_cnt_d = '0;
          // Activity on the threshold edge keeps the clock running.
          if (act) begin
            idle_cnt_d = '0;
          end else if (idle_cnt_q == IdleLast) begin
            state_d    = ST_GATED;
            idle_cnt_d = '0;
          end else if (idle_cnt_q != IdleMax) begin
            idle_cnt_d = idle_cnt_q + IcW'(1);
          end
        end
        ST_GATED: begin
          idle_cnt_d = '0;
          if (act) begin
            state_d    = ST_WAKE;
            wake_cnt_d = '0;
          end
        end
        ST_WAKE: begin
          // Settling runs to completion regardless of activity.
          idle_cnt_d = '0;
          if (wake_cnt_q == WakeLast) begin
            state_d    = ST_RUN;
            wake_cnt_d = '0;
          end else if (wake_cnt_q != WakeMax) begin
            wake_cnt_d = wake_cnt_q + WcW'(1);
          end
        end
        default: begin
          state_d    = ST_RUN;
          idle_cnt_d = '0;
          wake_cnt_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    en_d    = (state_d != ST_GATED);
    gated_d = (state_d == ST_GATED);
    ack_d   = ack_q;
    if (!req) begin
      ack_d = 1'b0;
    end else if (state_q == ST_RUN) begin
      ack_d = 1'b1;
    end
  end

  assign en    = en_q;
  assign ack   = ack_q;
  assign gated = gated_q;

endmodule

// File: tb/tb_la_clkgatectrl.sv
// tb/tb_la_clkgatectrl.sv - randomized bench for la_clkgatectrl against a timestamp model
module tb_la_clkgatectrl;

  localparam int IDLE = 16;
  localparam int WAKE = 2;

  logic clk;
  logic reset;
  logic busy;
  logic req;
  logic force_on;
  logic te;
  logic en;
  logic ack;
  logic gated;

  int n_checks = 0;
  int n_errors = 0;

  // Model: clock-off flag, quiet-edge run length, wake finish edge (-1 = not waking).
  bit m_off;
  int m_quiet;
  int m_wake_end;
  bit m_ack;
  int edge_no = 0;

  la_clkgatectrl #(
    .PROP ("DEFAULT"),
    .IDLE (IDLE),
    .WAKE (WAKE)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .busy     (busy),
    .req      (req),
    .force_on (force_on),
    .te       (te),
    .en       (en),
    .ack      (ack),
    .gated    (gated)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_no);
    end
  endtask

  task automatic model_step(input bit rs, input bit b, input bit r, input bit f, input bit t);
    bit act;
    bit in_run;
    edge_no++;
    act = b | r | f | t;
    if (rs) begin
      m_off = 1'b0; m_quiet = 0; m_wake_end = -1; m_ack = 1'b0;
      return;
    end
    in_run = !m_off && (m_wake_end < 0);
    if (!r) m_ack = 1'b0;
    else if (in_run) m_ack = 1'b1;
    if (t) begin
      m_off = 1'b0; m_quiet = 0; m_wake_end = -1;
    end else if (m_off) begin
      if (act) begin
        m_off = 1'b0;
        m_wake_end = edge_no + WAKE;
      end
    end else if (m_wake_end >= 0) begin
      if (edge_no == m_wake_end) begin
        m_wake_end = -1;
        m_quiet = 0;
      end
    end else begin
      m_quiet = act ? 0 : m_quiet + 1;
      if (m_quiet == IDLE) begin
        m_off = 1'b1;
        m_quiet = 0;
      end
    end
  endtask

  task automatic cycle(input bit b, input bit r, input bit f, input bit t, input bit rs);
    busy = b; req = r; force_on = f; te = t; reset = rs;
    @(posedge clk);
    model_step(rs, b, r, f, t);
    @(negedge clk);
    check("en", {31'd0, en}, {31'd0, !m_off});
    check("gated", {31'd0, gated}, {31'd0, m_off});
    check("ack", {31'd0, ack}, {31'd0, m_ack});
  endtask

  // Counts quiet edges until en falls; the first quiet edge counts as 1.
  task automatic measure_gate(output int n);
    n = 0;
    for (int i = 1; i <= 80; i++) begin
      cycle(0, 0, 0, 0, 0);
      if (!en) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int n;
    busy = 0; req = 0; force_on = 0; te = 0; reset = 1;
    m_off = 0; m_quiet = 0; m_wake_end = -1; m_ack = 0;

    cycle(0, 0, 0, 0, 1);
    cycle(1, 1, 1, 1, 1);
    check("reset_en", {31'd0, en}, 32'd1);
    check("reset_ack", {31'd0, ack}, 32'd0);
    check("reset_gated", {31'd0, gated}, 32'd0);

    // Busy for five edges, then quiet: IDLE edges to gate.
    for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0, 0);
    measure_gate(n);
    check("gate_latency", n, IDLE);
    check("gate_status", {31'd0, gated}, 32'd1);

    // Counter restart: busy pulse at idle count 10.
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < WAKE + 1; i++) cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    measure_gate(n);
    check("restart_latency", n, IDLE);

    // Wake handshake from GATED.
    cycle(0, 1, 0, 0, 0);
    check("wake_en", {31'd0, en}, 32'd1);
    n = 1;
    for (int i = 0; i < 20 && !ack; i++) begin
      cycle(0, 1, 0, 0, 0);
      n++;
    end
    check("ack_latency", n, WAKE + 2);
    cycle(0, 1, 0, 0, 0);
    busy = 0;
    req = 0;
    @(posedge clk);
    model_step(0, 0, 0, 0, 0);
    @(negedge clk);
    check("ack_drop", {31'd0, ack}, 32'd0);
    n = 1;
    for (int i = 0; i < 80 && en; i++) begin
      cycle(0, 0, 0, 0, 0);
      n++;
    end
    check("regate_after_ack", n, IDLE);

    // Threshold collision: activity on the IDLE-1 count edge.
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < WAKE; i++) cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < IDLE - 1; i++) cycle(0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    check("collision_en", {31'd0, en}, 32'd1);
    measure_gate(n);
    check("collision_then_gate", n, IDLE);

    // One-cycle req pulse in GATED: wake completes without ack, then re-gates.
    cycle(0, 1, 0, 0, 0);
    n = 0;
    for (int i = 0; i < 80; i++) begin
      cycle(0, 0, 0, 0, 0);
      if (ack) n = 1;
      if (!en) break;
    end
    check("pulse_no_ack", n, 0);
    check("pulse_regated", {31'd0, gated}, 32'd1);

    // te overrides GATED.
    cycle(0, 0, 0, 1, 0);
    check("te_en", {31'd0, en}, 32'd1);
    check("te_gated", {31'd0, gated}, 32'd0);

    // force_on holds the clock for well over IDLE.
    for (int i = 0; i < 3 * IDLE; i++) cycle(0, 0, 1, 0, 0);
    check("force_on_en", {31'd0, en}, 32'd1);

    // Reset during WAKE.
    measure_gate(n);
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1);
    check("wake_reset_en", {31'd0, en}, 32'd1);
    check("wake_reset_gated", {31'd0, gated}, 32'd0);
    measure_gate(n);
    check("wake_reset_counter", n, IDLE);

    // Randomized segments, checked every edge by the model.
    for (int s = 0; s < 400; s++) begin
      int kind;
      int len;
      kind = $urandom_range(0, 9);
      len  = $urandom_range(1, 5);
      case (kind)
        0, 1, 2, 3: begin
          len = $urandom_range(0, IDLE + 8);
          for (int i = 0; i < len; i++) cycle(0, 0, 0, 0, 0);
        end
        4: for (int i = 0; i < len; i++) cycle(1, 0, 0, 0, 0);
        5: begin
          for (int i = 0; i < 12 && !m_ack; i++) cycle($urandom_range(0, 1), 1, 0, 0, 0);
          cycle(0, 0, 0, 0, 0);
        end
        6: for (int i = 0; i < len; i++) cycle(0, 0, 1, 0, 0);
        7: for (int i = 0; i < len; i++) cycle(0, 0, 0, 1, 0);
        8: cycle(0, 0, 0, 0, 1);
        default: begin
          for (int i = 0; i < len; i++) begin
            logic [4:0] v;
            v = 5'($urandom);
            cycle(v[0], v[1], v[2] & v[3], v[4] & v[3] & v[2], 0);
          end
        end
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
